// File: rtl/systolic_output_collector.sv
// Drain end of the MAC array: captures skewed per-column psums of one output
// row, saturates each to OW bits and writes the row to the output buffer,
// then pulses row_done back to the array control unit.
module systolic_output_collector #(
    parameter int N       = 4,
    parameter int AW      = 32,
    parameter int OW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_row_start,
    input  logic [$clog2(N)-1:0]    i_row_dst,
    input  logic [N-1:0]            i_psum_valid,
    input  logic [N*AW-1:0]         i_psum_data,
    output logic                    o_mem_we,
    output logic [2*$clog2(N)-1:0]  o_mem_addr,
    output logic [OW-1:0]           o_mem_wdata,
    output logic                    o_row_done,
    output logic                    o_busy,
    output logic                    o_err_sticky,
    input  logic                    i_err_clr
);

    localparam int LN = $clog2(N);
    localparam int TW = $clog2(TIMEOUT + 1);

    // Saturation bounds held at accumulator width for a signed compare
    localparam logic [AW-1:0] SMAX = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic [AW-1:0] SMIN = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [LN-1:0]         r_dst;
    logic [LN-1:0]         r_col;
    logic [N-1:0]          r_mask;
    logic [TW-1:0]         r_timer;
    logic [N-1:0][AW-1:0]  r_cap;
    logic [N-1:0]          w_mask_nxt;
    logic                  w_timeout;
    logic                  w_err_set;

    function automatic logic [OW-1:0] sat(input logic [AW-1:0] x);
        if ($signed(x) > $signed(SMAX))      return SMAX[OW-1:0];
        else if ($signed(x) < $signed(SMIN)) return SMIN[OW-1:0];
        else                                 return x[OW-1:0];
    endfunction

    assign o_busy = (r_state != S_IDLE);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state; the mask check includes this cycle's captures so the last
    // capture edge also moves to WRITE
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        w_mask_nxt  = r_mask | i_psum_valid;
        case (r_state)
            S_IDLE:    if (i_row_start) w_state_nxt = S_COLLECT;
            S_COLLECT: begin
                if (&w_mask_nxt) begin
                    w_state_nxt = S_WRITE;
                end else if (r_timer == TW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_WRITE:   if (r_col == LN'(N - 1)) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        w_err_set = ((r_state == S_IDLE) && (|i_psum_valid)) ||
                    ((r_state == S_COLLECT) && (|(i_psum_valid & r_mask))) ||
                    w_timeout;
    end

    // Capture path: destination latch, first-value-wins capture, timer, column walk
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dst   <= '0;
            r_col   <= '0;
            r_mask  <= '0;
            r_timer <= '0;
            r_cap   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_row_start) begin
                        r_dst   <= i_row_dst;
                        r_mask  <= '0;
                        r_timer <= '0;
                    end
                end
                S_COLLECT: begin
                    for (int j = 0; j < N; j++)
                        if (i_psum_valid[j] && !r_mask[j])
                            r_cap[j] <= i_psum_data[j*AW +: AW];
                    r_mask  <= w_mask_nxt;
                    r_timer <= r_timer + TW'(1);
                    r_col   <= '0;
                end
                S_WRITE: r_col <= r_col + LN'(1);
                default: ;
            endcase
        end
    end

    // Registered buffer write port and completion pulse; addr/data zero when idle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_row_done  <= 1'b0;
        end else begin
            o_mem_we    <= (r_state == S_WRITE);
            o_mem_addr  <= (r_state == S_WRITE) ? {r_dst, r_col} : '0;
            o_mem_wdata <= (r_state == S_WRITE) ? sat(r_cap[r_col]) : '0;
            o_row_done  <= (r_state == S_DONE);
        end
    end

    // Sticky error; a new error beats a same-cycle clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       o_err_sticky <= 1'b0;
        else if (w_err_set) o_err_sticky <= 1'b1;
        else if (i_err_clr) o_err_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed bench for systolic_output_collector (N=4, AW=32, OW=16, TIMEOUT=64).
module tb_systolic_output_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         row_start;
    logic [1:0]   row_dst;
    logic [3:0]   psum_valid;
    logic [127:0] psum_data;
    logic         mem_we;
    logic [3:0]   mem_addr;
    logic [15:0]  mem_wdata;
    logic         row_done;
    logic         busy;
    logic         err_sticky;
    logic         err_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    int done_cnt = 0;

    systolic_output_collector #(.N(4), .AW(32), .OW(16), .TIMEOUT(64)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_row_start(row_start), .i_row_dst(row_dst),
        .i_psum_valid(psum_valid), .i_psum_data(psum_data),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_row_done(row_done), .o_busy(busy), .o_err_sticky(err_sticky),
        .i_err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we)   we_cnt++;
        if (row_done) done_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a row, feed one column per cycle, then check the 4 writes and row_done
    task automatic do_row(input int dst, input int d0, input int d1, input int d2, input int d3,
                          input int e0, input int e1, input int e2, input int e3);
        int d[4];
        int e[4];
        d = '{d0, d1, d2, d3};
        e = '{e0, e1, e2, e3};
        row_start = 1'b1;
        row_dst   = dst[1:0];
        tick();
        row_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            psum_valid = 4'b0001 << j;
            psum_data[j*32 +: 32] = d[j];
            tick();
        end
        psum_valid = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("row_we",   int'(mem_we), 1);
            chk("row_addr", int'(mem_addr), dst*4 + k);
            chk("row_data", int'($signed(mem_wdata)), e[k]);
        end
        tick();
        chk("row_done", int'(row_done), 1);
        chk("row_we_off", int'(mem_we), 0);
        tick();
        chk("row_done_once", int'(row_done), 0);
        chk("row_idle", int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_done;
        int base_we;
        rst_n = 1'b0; row_start = 1'b0; row_dst = '0; psum_valid = '0;
        psum_data = '0; err_clr = 1'b0;
        #22;
        chk("rst_we", int'(mem_we), 0);
        chk("rst_addr", int'(mem_addr), 0);
        chk("rst_data", int'(mem_wdata), 0);
        chk("rst_done", int'(row_done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err_sticky), 0);
        rst_n = 1'b1;
        tick();

        // 1: skewed valids into row 2
        do_row(2, 5, -7, 100, 0, 5, -7, 100, 0);
        chk("t1_err", int'(err_sticky), 0);

        // 2: saturation
        do_row(0, 40000, -40000, 32767, -32768, 32767, -32768, 32767, -32768);

        // 3a: all columns in one cycle; writes follow on the next cycle
        row_start = 1'b1; row_dst = 2'd3; tick();
        row_start = 1'b0;
        psum_valid = 4'b1111;
        psum_data = {32'd44, 32'd33, 32'd22, 32'd11};
        tick();
        psum_valid = '0;
        psum_data = '0;
        chk("t3_busy", int'(busy), 1);
        tick();
        chk("t3_we0", int'(mem_we), 1);
        chk("t3_addr0", int'(mem_addr), 12);
        chk("t3_data0", int'(mem_wdata), 11);
        tick(); tick(); tick();
        chk("t3_addr3", int'(mem_addr), 15);
        chk("t3_data3", int'(mem_wdata), 44);
        tick();
        chk("t3_done", int'(row_done), 1);
        // stray repeat of column 1 now lands in IDLE
        psum_valid = 4'b0010;
        tick();
        psum_valid = '0;
        chk("t3_idle_err", int'(err_sticky), 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t3_clr", int'(err_sticky), 0);

        // 3b: duplicate while still collecting keeps the first value
        row_start = 1'b1; row_dst = 2'd1; tick();
        row_start = 1'b0;
        psum_valid = 4'b0001; psum_data[31:0] = 32'd11; tick();
        psum_valid = 4'b0001; psum_data[31:0] = 32'd99; tick();
        chk("t3b_dup_err", int'(err_sticky), 1);
        psum_valid = 4'b1110; psum_data = {32'd4, 32'd3, 32'd2, 32'd99}; tick();
        psum_valid = '0;
        tick();
        chk("t3b_addr0", int'(mem_addr), 4);
        chk("t3b_first", int'(mem_wdata), 11);
        tick(); tick(); tick(); tick();
        chk("t3b_done", int'(row_done), 1);

        // error beats same-cycle clear
        tick();
        psum_valid = 4'b0100; err_clr = 1'b1; tick();
        psum_valid = '0; err_clr = 1'b0;
        chk("err_wins", int'(err_sticky), 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("err_clr", int'(err_sticky), 0);

        // 4: timeout with column 3 missing
        base_done = done_cnt; base_we = we_cnt;
        row_start = 1'b1; row_dst = 2'd0; tick();
        row_start = 1'b0;
        psum_valid = 4'b0111; tick();
        psum_valid = '0;
        repeat (62) tick();
        chk("t4_not_yet", int'(err_sticky), 0);
        chk("t4_busy", int'(busy), 1);
        tick();
        chk("t4_err", int'(err_sticky), 1);
        chk("t4_no_done_yet", int'(row_done), 0);
        tick();
        chk("t4_done", int'(row_done), 1);
        repeat (3) tick();
        chk("t4_done_count", done_cnt - base_done, 1);
        chk("t4_no_writes", we_cnt - base_we, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t4_clr", int'(err_sticky), 0);

        // 5: full matrix, rows 0..3
        base_done = done_cnt; base_we = we_cnt;
        for (int r = 0; r < 4; r++)
            do_row(r, r*10 + 1, r*10 + 2, -(r*10 + 3), r*10 + 4,
                   r*10 + 1, r*10 + 2, -(r*10 + 3), r*10 + 4);
        tick();
        chk("t5_writes", we_cnt - base_we, 16);
        chk("t5_dones", done_cnt - base_done, 4);
        chk("t5_err", int'(err_sticky), 0);

        // 6: reset after two writes
        base_done = done_cnt;
        row_start = 1'b1; row_dst = 2'd2; tick();
        row_start = 1'b0;
        psum_valid = 4'b1111; psum_data = {32'd8, 32'd7, 32'd6, 32'd5}; tick();
        psum_valid = '0;
        tick(); tick();
        chk("t6_we_pre", int'(mem_we), 1);
        chk("t6_addr_pre", int'(mem_addr), 9);
        rst_n = 1'b0;
        #1;
        chk("t6_we", int'(mem_we), 0);
        chk("t6_addr", int'(mem_addr), 0);
        chk("t6_data", int'(mem_wdata), 0);
        chk("t6_busy", int'(busy), 0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t6_no_done", done_cnt - base_done, 0);
        do_row(1, 1, 2, 3, 4, 1, 2, 3, 4);
        chk("t6_err", int'(err_sticky), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
